// File: rtl/la_iodirctrl_pkg.sv
// Shared constants and sizing helper for the I/O direction controller.
package la_iodirctrl_pkg;

  localparam int unsigned TCNT_W = 8;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    int unsigned w;
    w = $clog2(maxval + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/la_iodirctrl.sv
// Direction controller for a bidirectional A/B pair: arbitrates drive requests,
// inserts dead cycles on every direction flip and bounds each side's hold time.
module la_iodirctrl
  import la_iodirctrl_pkg::*;
#(
  parameter int unsigned TURN        = 2,
  parameter int unsigned HOLDMAX     = 16,
  parameter bit          DEFAULT_A2B = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt,
  output logic a_oe,
  output logic b_oe,
  output logic a2b,
  output logic turn,
  output logic busy
);

  localparam int unsigned HCNT_W = cnt_width(HOLDMAX);
  localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TURN - 32'd1);
  localparam logic [HCNT_W-1:0] HOLD_SAT  = HCNT_W'(HOLDMAX);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((HOLDMAX == 32'd0) ? 32'd0 : HOLDMAX - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                a2b_q, a2b_d;
  logic                tgt_a_q, tgt_a_d;
  logic                last_a_q, last_a_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [HCNT_W-1:0]   hcnt_inc_s;
  logic                yield_s;
  logic                a_gnt_q, b_gnt_q, turn_q, busy_q;

  assign yield_s    = (HOLDMAX != 32'd0) && (hcnt_q == HOLD_LAST);
  assign hcnt_inc_s = (hcnt_q == HOLD_SAT) ? hcnt_q : hcnt_q + HCNT_W'(1);

  // Next-state arbitration; every direction change is routed through ST_TURN.
  always_comb begin
    state_d  = state_q;
    a2b_d    = a2b_q;
    tgt_a_d  = tgt_a_q;
    last_a_d = last_a_q;
    tcnt_d   = tcnt_q;
    hcnt_d   = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req && (!b_req || !last_a_q)) begin
          if (a2b_q) begin
            state_d  = ST_OWN_A;
            hcnt_d   = '0;
            last_a_d = 1'b1;
          end else begin
            state_d = ST_TURN;
            tgt_a_d = 1'b1;
            a2b_d   = 1'b1;
            tcnt_d  = TCNT_LOAD;
          end
        end else if (b_req) begin
          if (!a2b_q) begin
            state_d  = ST_OWN_B;
            hcnt_d   = '0;
            last_a_d = 1'b0;
          end else begin
            state_d = ST_TURN;
            tgt_a_d = 1'b0;
            a2b_d   = 1'b0;
            tcnt_d  = TCNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_A: begin
        if (b_req && (!a_req || yield_s)) begin
          state_d = ST_TURN;
          tgt_a_d = 1'b0;
          a2b_d   = 1'b0;
          tcnt_d  = TCNT_LOAD;
        end else if (!a_req) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_inc_s;
        end
      end
      ST_OWN_B: begin
        if (a_req && (!b_req || yield_s)) begin
          state_d = ST_TURN;
          tgt_a_d = 1'b1;
          a2b_d   = 1'b1;
          tcnt_d  = TCNT_LOAD;
        end else if (!b_req) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_inc_s;
        end
      end
      ST_TURN: begin
        // The dead time always runs to completion; the request is only re-checked at the end.
        if (tcnt_q != TCNT_W'(0)) begin
          tcnt_d = tcnt_q - TCNT_W'(1);
        end else if (tgt_a_q && a_req) begin
          state_d  = ST_OWN_A;
          hcnt_d   = '0;
          last_a_d = 1'b1;
        end else if (!tgt_a_q && b_req) begin
          state_d  = ST_OWN_B;
          hcnt_d   = '0;
          last_a_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      a2b_q    <= DEFAULT_A2B;
      tgt_a_q  <= 1'b0;
      last_a_q <= 1'b0;
      tcnt_q   <= '0;
      hcnt_q   <= '0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      turn_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a2b_q    <= a2b_d;
      tgt_a_q  <= tgt_a_d;
      last_a_q <= last_a_d;
      tcnt_q   <= tcnt_d;
      hcnt_q   <= hcnt_d;
      a_gnt_q  <= (state_d == ST_OWN_A);
      b_gnt_q  <= (state_d == ST_OWN_B);
      turn_q   <= (state_d == ST_TURN);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign a_gnt = a_gnt_q;
  assign b_gnt = b_gnt_q;
  assign a_oe  = a_gnt_q;
  assign b_oe  = b_gnt_q;
  assign a2b   = a2b_q;
  assign turn  = turn_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_la_iodirctrl.sv
// Self-checking bench for la_iodirctrl: directed scenarios plus random requests
// compared every cycle against an owner/dead-time reference model.
module tb_la_iodirctrl;

  localparam int TURN_P  = 2;
  localparam int HOLD_P  = 4;
  localparam bit DEF_A2B = 1'b0;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic a_req = 1'b0;
  logic b_req = 1'b0;
  logic a_gnt, b_gnt, a_oe, b_oe, a2b, turn, busy;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: owner 0=none 1=A 2=B, dead cycles left, held cycles.
  int m_owner, m_dead, m_tgt, m_held, m_last;
  bit m_dir;
  int last_side, zero_run;

  la_iodirctrl #(.TURN(TURN_P), .HOLDMAX(HOLD_P), .DEFAULT_A2B(DEF_A2B)) dut (
    .clk(clk), .nreset(nreset), .a_req(a_req), .b_req(b_req),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_oe(a_oe), .b_oe(b_oe),
    .a2b(a2b), .turn(turn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_owner = 0; m_dead = 0; m_tgt = 0; m_held = 0; m_last = 2; m_dir = DEF_A2B;
    last_side = 0; zero_run = 0;
  endtask

  task automatic m_take(input int w);
    m_owner = w; m_held = 1; m_last = w;
  endtask

  task automatic m_start_turn(input int w);
    m_owner = 0; m_tgt = w; m_dir = (w == 1); m_dead = TURN_P;
  endtask

  task automatic model_update(input bit a, input bit b);
    bit req [1:2];
    int other, w;
    req[1] = a; req[2] = b;
    if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0 && req[m_tgt]) m_take(m_tgt);
    end else if (m_owner != 0) begin
      other = 3 - m_owner;
      if (req[other] && (!req[m_owner] || (HOLD_P != 0 && m_held == HOLD_P))) m_start_turn(other);
      else if (!req[m_owner]) m_owner = 0;
      else m_held++;
    end else begin
      if (req[1] && req[2]) w = 3 - m_last;
      else if (req[1]) w = 1;
      else if (req[2]) w = 2;
      else w = 0;
      if (w != 0) begin
        if (m_dir == (w == 1)) m_take(w);
        else m_start_turn(w);
      end
    end
  endtask

  task automatic compare_all();
    int side;
    chk("a_gnt", a_gnt, m_owner == 1);
    chk("b_gnt", b_gnt, m_owner == 2);
    chk("a_oe", a_oe, m_owner == 1);
    chk("b_oe", b_oe, m_owner == 2);
    chk("a2b", a2b, m_dir);
    chk("turn", turn, m_dead > 0);
    chk("busy", busy, (m_owner != 0) || (m_dead > 0));
    chk("excl", a_oe & b_oe, 0);
    if (a_oe | b_oe) begin
      side = a_oe ? 1 : 2;
      if (last_side != 0 && side != last_side) chk("gap", zero_run >= TURN_P, 1);
      last_side = side;
      zero_run = 0;
    end else begin
      zero_run++;
    end
  endtask

  task automatic step(input bit a, input bit b);
    @(negedge clk);
    a_req = a; b_req = b;
    @(posedge clk);
    model_update(a, b);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    m_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  // Called just after a step (posedge+1): drops reset between clock edges.
  task automatic reset_mid(input string tag);
    #2;
    nreset = 1'b0;
    #1;
    chk({tag, "_aoe"}, a_oe, 0);
    chk({tag, "_boe"}, b_oe, 0);
    chk({tag, "_a2b"}, a2b, DEF_A2B);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_turn"}, turn, 0);
    m_reset();
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt, tc;
    bit ra, rb;
    m_reset();
    #1 nreset = 1'b0;
    #2;
    chk("rst_a2b", a2b, DEF_A2B);
    chk("rst_aoe", a_oe, 0);
    chk("rst_boe", b_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_turn", turn, 0);
    @(negedge clk);
    nreset = 1'b1;

    // B with matching direction: one-cycle latency, no turnaround.
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      if (b_gnt) cnt++;
      chk("t1_turn", turn, 0);
    end
    chk("t1_bcnt", cnt, 3);
    step(1'b0, 1'b0);
    chk("t1_bdrop", b_gnt, 0);

    // A from reset needs TURN dead cycles.
    do_reset();
    step(1'b1, 1'b0);
    chk("t2_turn0", turn, 1); chk("t2_a2b", a2b, 1); chk("t2_agnt0", a_gnt, 0);
    step(1'b1, 1'b0);
    chk("t2_turn1", turn, 1); chk("t2_agnt1", a_gnt, 0);
    step(1'b1, 1'b0);
    chk("t2_agnt", a_gnt, 1); chk("t2_turn2", turn, 0);
    step(1'b0, 1'b0);
    chk("t2_idle", busy, 0);

    // Tie after reset: A wins, then B after exactly TURN dead cycles.
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("t3_afirst", a_gnt, 1); chk("t3_bno", b_gnt, 0);
    step(1'b1, 1'b1);
    tc = 0; k = 0;
    step(1'b0, 1'b1);
    while (!b_gnt && k < 10) begin
      if (turn) tc++;
      step(1'b0, 1'b1);
      k++;
    end
    if (turn) tc++;
    chk("t3_dead", tc, TURN_P);
    chk("t3_bgnt", b_gnt, 1);
    step(1'b0, 1'b0);

    // Forced yield after HOLDMAX owned cycles.
    do_reset();
    k = 0;
    while (!a_gnt && k < 6) begin step(1'b1, 1'b0); k++; end
    chk("t4_own", a_gnt, 1);
    cnt = 0; k = 0;
    while (a_gnt && k < 12) begin step(1'b1, 1'b1); cnt++; k++; end
    chk("t4_hold", cnt, HOLD_P);
    tc = 0; k = 0;
    while (turn && k < 12) begin step(1'b1, 1'b1); tc++; k++; end
    chk("t4_turn", tc, TURN_P);
    chk("t4_bgnt", b_gnt, 1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Request withdrawn mid-turnaround: dead time still completes.
    do_reset();
    step(1'b1, 1'b0);
    chk("t5_turn0", turn, 1);
    step(1'b0, 1'b0);
    chk("t5_turn1", turn, 1);
    step(1'b0, 1'b0);
    chk("t5_turn2", turn, 0); chk("t5_agnt", a_gnt, 0); chk("t5_busy", busy, 0);

    // Asynchronous reset while B owns, then while A owns.
    do_reset();
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    chk("t6_bown", b_oe, 1);
    reset_mid("t6b");
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("t6_aown", a_oe, 1);
    reset_mid("t6a");

    // Random level requests against the reference model.
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      step(ra, rb);
      if (i == 300) reset_mid("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/la_iodirctrl.md
Name: la_iodirctrl

Overview:
- Direction controller sitting directly upstream of the bidirectional short/pad pair.
- Arbitrates drive requests from side A and side B and generates the registered a2b direction bit and the per-side tristate enables that feed that stage.
- Inserts guaranteed dead (turnaround) cycles whenever direction flips, so the two sides never drive concurrently.
- Enforces a bounded hold time so neither side can starve the other.

Parameters:
- TURN, 2, turnaround dead cycles inserted on every direction change; legal range 1..255.
- HOLDMAX, 16, maximum owned cycles before a forced yield when the other side is requesting; 0 disables forced yield.
- DEFAULT_A2B, 0, a2b value at reset (0 = B drives toward A).

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous active-low reset.
- a_req  input  1  side A requests to drive (level, held until done).
- b_req  input  1  side B requests to drive.
- a_gnt  output  1  side A owns the bus this cycle.
- b_gnt  output  1  side B owns the bus this cycle.
- a_oe  output  1  side A output enable (equals a_gnt).
- b_oe  output  1  side B output enable (equals b_gnt).
- a2b  output  1  direction to downstream short: 1 = A drives B, 0 = B drives A.
- turn  output  1  turnaround in progress.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset nreset is asynchronous, active-low.
- Outputs: all outputs are registered.
- Reset values: state IDLE, a_gnt/b_gnt/a_oe/b_oe/turn/busy = 0, a2b = DEFAULT_A2B, last-served flag = B (A wins the first tie), both counters 0.
- States: IDLE, OWN_A, OWN_B, TURN. A target register (A or B) records who is owed the bus.
- IDLE:
  - Both enables 0; a2b holds its last value.
  - Only a_req set: go to OWN_A if a2b==1, else go to TURN with target A.
  - Only b_req set: symmetric, with OWN_B when a2b==0.
  - Both set: the side not last served wins.
- Grant latency:
  - Req sampled high at edge k with matching direction: gnt high after edge k (1 cycle).
  - Mismatched direction: gnt high after edge k+TURN.
- TURN:
  - a2b updates to the target direction on entry.
  - a_oe, b_oe, a_gnt, b_gnt are all 0; turn = 1.
  - Down-counter loads TURN-1 on entry; on reaching 0 go to OWN_<target> if target's req is still 1, else go to IDLE.
  - A req dropping mid-turnaround never shortens the dead time.
- OWN_A (OWN_B symmetric):
  - a_gnt = a_oe = 1; last-served flag set to A on entry.
  - Hold counter clears on entry and increments each owned cycle, saturating at HOLDMAX.
  - a_req falls with b_req = 1: go to TURN, target B.
  - a_req falls with b_req = 0: go to IDLE; gnt/oe drop after the edge sampling a_req low.
  - Forced yield: HOLDMAX != 0, hold count == HOLDMAX-1, and b_req = 1: go to TURN, target B, even though a_req is still 1.
  - A keeps requesting after a forced yield: it re-enters through a later TURN once B releases or is itself forced out.
- Invariant: a_oe & b_oe is never 1. At least TURN cycles with both enables 0 separate any a_oe and b_oe high period.
- Simultaneous release and opposite request on the same edge: handled as "other pending", i.e. go to TURN.
- Reset asserted mid-operation: all enables drop immediately (asynchronous), a2b returns to DEFAULT_A2B, and in-flight turnaround and hold counts are discarded.
- Counter widths: turnaround counter is 8 bits; hold counter is $clog2(HOLDMAX+1) bits, minimum 1.

Decomposition:
- State encoding as localparams inside the module; no shared package typedefs needed.
- No sub-module required. The turnaround down-counter is small enough to stay inline.
- The downstream short/pad instance is not instantiated here; the integration level wires a2b and the enables to it.

Test Plan:
- Reset, DEFAULT_A2B=0: a2b=0, all enables 0. Pulse b_req for 3 cycles -> b_gnt high 1 cycle later for 3 cycles, turn never set.
- From reset, TURN=2, raise a_req -> turn high 2 cycles, a2b=1 at turn start, a_gnt high on the third cycle after the sampling edge.
- a_req and b_req raised together from IDLE with last served = B -> A granted first; after A releases, B granted after exactly 2 dead cycles.
- HOLDMAX=4, A owns, b_req raised and a_req held -> a_gnt drops after 4 owned cycles, 2 turn cycles, then b_gnt = 1.
- In TURN toward A, drop a_req after 1 cycle -> turnaround still completes 2 cycles, then IDLE with all grants 0.
- Assert nreset while OWN_B -> b_oe falls without waiting for a clock edge; a2b = DEFAULT_A2B. Throughout all tests, assert a_oe & b_oe == 0 every cycle.
